// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU, load) writeback arbiter sharing the single register-file write port.
// Define WB_RR_ARB_EN for round-robin arbitration; otherwise loads have fixed priority over ALU.
module regfile_wb_arbiter #(
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_AluValid,
   output logic              o_AluReady,
   input  logic [4:0]        i_AluRd,
   input  logic [DATA_W-1:0] i_AluData,
   input  logic              i_MemValid,
   output logic              o_MemReady,
   input  logic [4:0]        i_MemRd,
   input  logic [DATA_W-1:0] i_MemData,
   output logic              o_RegWrite,
   output logic [4:0]        o_WriteReg,
   output logic [DATA_W-1:0] o_WriteData,
   output logic [31:0]       o_PendingMask,
   output logic              o_Idle
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Index 0 is the ALU requester, index 1 the load requester.
   logic              in_valid  [2];
   logic [4:0]        in_rd     [2];
   logic [DATA_W-1:0] in_data   [2];
   logic              ready     [2];
   logic              head_vld  [2];
   logic [4:0]        head_rd   [2];
   logic [DATA_W-1:0] head_data [2];
   logic [1:0]        grant;

   logic              reg_write_q, reg_write_d;
   logic [4:0]        write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;

   assign in_valid[0] = i_AluValid;
   assign in_rd[0]    = i_AluRd;
   assign in_data[0]  = i_AluData;
   assign in_valid[1] = i_MemValid;
   assign in_rd[1]    = i_MemRd;
   assign in_data[1]  = i_MemData;

   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [4:0]        rd_mem   [FIFO_DEPTH];
      logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
      logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, off;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic              push;
      logic [31:0]       pend;

      assign ready[gi]     = (cnt_q != CNT_W'(FIFO_DEPTH));
      // Writes to x0 complete the handshake but are never queued.
      assign push          = in_valid[gi] && ready[gi] && (in_rd[gi] != 5'd0);
      assign head_vld[gi]  = (cnt_q != '0);
      assign head_rd[gi]   = rd_mem[rptr_q];
      assign head_data[gi] = data_mem[rptr_q];

      always_comb begin
         wptr_d = wptr_q + PTR_W'(push);
         rptr_d = rptr_q + PTR_W'(grant[gi]);
         cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(grant[gi]);
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
         end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
         end
      end

      always_ff @(posedge i_clk) begin
         if (push) begin
            rd_mem[wptr_q]   <= in_rd[gi];
            data_mem[wptr_q] <= in_data[gi];
         end
      end

      // An entry is live when its distance from the read pointer is below the count.
      always_comb begin
         pend = '0;
         off  = '0;
         for (int e = 0; e < FIFO_DEPTH; e++) begin
            off = PTR_W'(e) - rptr_q;
            if (CNT_W'(off) < cnt_q) pend[rd_mem[e]] = 1'b1;
         end
      end
   end

`ifdef WB_RR_ARB_EN
   logic rr_alu_last_q, rr_alu_last_d;

   always_comb begin
      grant         = {head_vld[1], head_vld[0]};
      rr_alu_last_d = rr_alu_last_q;
      if (head_vld[0] && head_vld[1]) begin
         grant         = rr_alu_last_q ? 2'b10 : 2'b01;
         rr_alu_last_d = !rr_alu_last_q;
      end
   end

   // Reset to "ALU granted last" so the first contended grant goes to loads.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rr_alu_last_q <= 1'b1;
      else          rr_alu_last_q <= rr_alu_last_d;
   end
`else
   always_comb begin
      grant = {head_vld[1], head_vld[0] && !head_vld[1]};
   end
`endif

   always_comb begin
      reg_write_d  = |grant;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (grant[1]) begin
         write_reg_d  = head_rd[1];
         write_data_d = head_data[1];
      end else if (grant[0]) begin
         write_reg_d  = head_rd[0];
         write_data_d = head_data[0];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign o_AluReady    = ready[0];
   assign o_MemReady    = ready[1];
   assign o_RegWrite    = reg_write_q;
   assign o_WriteReg    = write_reg_q;
   assign o_WriteData   = write_data_q;
   assign o_PendingMask = (g_fifo[0].pend | g_fifo[1].pend
                          | (reg_write_q ? (32'd1 << write_reg_q) : 32'd0)) & ~32'd1;
   assign o_Idle        = !head_vld[0] && !head_vld[1] && !reg_write_q;
endmodule
